colour_conversion_controller: RTL and testbench



---
 rtl/colour_conversion_pkg.sv | 35 +++
 rtl/colour_conversion_controller.sv | 204 ++++++++++++++++++++
 tb/tb_colour_conversion_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/colour_conversion_pkg.sv
// Shared constants for the YUV->RGB conversion sequencer: state encodings,
// datapath mux selects and the default memory plane layout.
package colour_conversion_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_RD_Y   = 4'd1;
  localparam state_t ST_RD_U   = 4'd2;
  localparam state_t ST_RD_V   = 4'd3;
  localparam state_t ST_WAIT_V = 4'd4;
  localparam state_t ST_C0     = 4'd5;
  localparam state_t ST_C1     = 4'd6;
  localparam state_t ST_C2     = 4'd7;
  localparam state_t ST_C3     = 4'd8;
  localparam state_t ST_C4     = 4'd9;
  localparam state_t ST_C5     = 4'd10;
  localparam state_t ST_DONE   = 4'd11;

  localparam logic [1:0] SMUX2_R    = 2'd0;
  localparam logic [1:0] SMUX2_G    = 2'd1;
  localparam logic [1:0] SMUX2_B    = 2'd2;
  localparam logic [1:0] SMUX2_IDLE = 2'd3;

  localparam logic SMUX1_EVEN = 1'b1;
  localparam logic SMUX1_ODD  = 1'b0;

  localparam int DEF_PAIRS  = 38400;
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_Y_BASE = 0;
  localparam int DEF_U_BASE = 38400;
  localparam int DEF_V_BASE = 76800;
  localparam int DEF_W_BASE = 115200;

endpackage

// File: rtl/colour_conversion_controller.sv
// Sequencer for the YUV->RGB datapath: per pixel pair it reads Y/U/V words,
// steers six component computations and writes three RGB words.
//
// state  | meaning
// IDLE   | waiting for start
// RD_Y   | read Y word
// RD_U   | read U word, latch Y bytes
// RD_V   | read V word, latch U bytes
// WAIT_V | latch V bytes
// C0..C5 | even R,G,B then odd R,G,B; odd steps write one word each
// DONE   | one-cycle done pulse
module colour_conversion_controller
  import colour_conversion_pkg::*;
#(
  parameter int PAIRS  = DEF_PAIRS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int Y_BASE = DEF_Y_BASE,
  parameter int U_BASE = DEF_U_BASE,
  parameter int V_BASE = DEF_V_BASE,
  parameter int W_BASE = DEF_W_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              R_en,
  output logic [ADDR_W-1:0] R_addr,
  output logic              W_en,
  output logic [ADDR_W-1:0] W_addr,
  output logic              Yen_even,
  output logic              Yen_odd,
  output logic              Uen_even,
  output logic              Uen_odd,
  output logic              Ven_even,
  output logic              Ven_odd,
  output logic              Smux1,
  output logic [1:0]        Smux2,
  output logic              Temp_en,
  output logic              Cen,
  output logic              end_of_pixel
);

  localparam int K_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  localparam logic [ADDR_W-1:0] Y_B = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0] U_B = ADDR_W'(U_BASE);
  localparam logic [ADDR_W-1:0] V_B = ADDR_W'(V_BASE);
  localparam logic [ADDR_W-1:0] W_B = ADDR_W'(W_BASE);
  localparam logic [K_W-1:0]    K_LAST = K_W'(PAIRS - 1);

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ADDR_W-1:0]   wbase_q, wbase_d;
  logic                last_pair;

  assign last_pair = (k_q == K_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      wbase_q <= W_B;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wbase_q <= wbase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wbase_d = wbase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD_Y;
          k_d     = '0;
          wbase_d = W_B;
        end
      end
      ST_RD_Y:   state_d = ST_RD_U;
      ST_RD_U:   state_d = ST_RD_V;
      ST_RD_V:   state_d = ST_WAIT_V;
      ST_WAIT_V: state_d = ST_C0;
      ST_C0:     state_d = ST_C1;
      ST_C1:     state_d = ST_C2;
      ST_C2:     state_d = ST_C3;
      ST_C3:     state_d = ST_C4;
      ST_C4:     state_d = ST_C5;
      ST_C5: begin
        if (last_pair) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_Y;
          k_d     = k_q + K_W'(1);
          wbase_d = wbase_q + ADDR_W'(3);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        k_d     = '0;
        wbase_d = W_B;
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
        wbase_d = W_B;
      end
    endcase
  end

  // Outputs are a pure decode of state and pair index.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    R_en         = 1'b0;
    R_addr       = '0;
    W_en         = 1'b0;
    W_addr       = '0;
    Yen_even     = 1'b0;
    Yen_odd      = 1'b0;
    Uen_even     = 1'b0;
    Uen_odd      = 1'b0;
    Ven_even     = 1'b0;
    Ven_odd      = 1'b0;
    Smux1        = SMUX1_ODD;
    Smux2        = SMUX2_IDLE;
    Temp_en      = 1'b0;
    Cen          = 1'b0;
    end_of_pixel = 1'b0;
    unique case (state_q)
      ST_RD_Y: begin
        busy   = 1'b1;
        R_en   = 1'b1;
        R_addr = Y_B + ADDR_W'(k_q);
      end
      ST_RD_U: begin
        busy     = 1'b1;
        R_en     = 1'b1;
        R_addr   = U_B + ADDR_W'(k_q);
        Yen_even = 1'b1;
        Yen_odd  = 1'b1;
      end
      ST_RD_V: begin
        busy     = 1'b1;
        R_en     = 1'b1;
        R_addr   = V_B + ADDR_W'(k_q);
        Uen_even = 1'b1;
        Uen_odd  = 1'b1;
      end
      ST_WAIT_V: begin
        busy     = 1'b1;
        Ven_even = 1'b1;
        Ven_odd  = 1'b1;
      end
      ST_C0: begin
        busy    = 1'b1;
        Smux1   = SMUX1_EVEN;
        Smux2   = SMUX2_R;
        Temp_en = 1'b1;
      end
      ST_C1: begin
        busy   = 1'b1;
        Smux1  = SMUX1_EVEN;
        Smux2  = SMUX2_G;
        W_en   = 1'b1;
        W_addr = wbase_q;
      end
      ST_C2: begin
        busy    = 1'b1;
        Smux1   = SMUX1_EVEN;
        Smux2   = SMUX2_B;
        Temp_en = 1'b1;
      end
      ST_C3: begin
        busy   = 1'b1;
        Smux1  = SMUX1_ODD;
        Smux2  = SMUX2_R;
        W_en   = 1'b1;
        W_addr = wbase_q + ADDR_W'(1);
      end
      ST_C4: begin
        busy    = 1'b1;
        Smux1   = SMUX1_ODD;
        Smux2   = SMUX2_G;
        Temp_en = 1'b1;
      end
      ST_C5: begin
        busy         = 1'b1;
        Smux1        = SMUX1_ODD;
        Smux2        = SMUX2_B;
        W_en         = 1'b1;
        W_addr       = wbase_q + ADDR_W'(2);
        Cen          = 1'b1;
        end_of_pixel = last_pair;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_colour_conversion_controller.sv
// Directed bench for colour_conversion_controller with a two-pair frame,
// a toy memory returning 0x8080 and a small YUV->RGB datapath model.
module tb_colour_conversion_controller;

  localparam int P  = 2;
  localparam int AW = 18;
  localparam int YB = 0;
  localparam int UB = 38400;
  localparam int VB = 76800;
  localparam int WB = 115200;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [5:0]    en;
    logic          smux1;
    logic [1:0]    smux2;
    logic          temp_en;
    logic          cen;
    logic          eop;
  } vec_t;

  typedef struct {
    int   cyc;
    logic start;
    vec_t exp;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, R_en, W_en;
  logic [AW-1:0] R_addr, W_addr;
  logic Yen_even, Yen_odd, Uen_even, Uen_odd, Ven_even, Ven_odd;
  logic Smux1, Temp_en, Cen, end_of_pixel;
  logic [1:0] Smux2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  colour_conversion_controller #(
    .PAIRS(P), .ADDR_W(AW), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .W_BASE(WB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .R_en(R_en), .R_addr(R_addr), .W_en(W_en), .W_addr(W_addr),
    .Yen_even(Yen_even), .Yen_odd(Yen_odd), .Uen_even(Uen_even), .Uen_odd(Uen_odd),
    .Ven_even(Ven_even), .Ven_odd(Ven_odd), .Smux1(Smux1), .Smux2(Smux2),
    .Temp_en(Temp_en), .Cen(Cen), .end_of_pixel(end_of_pixel)
  );

  vec_t act;
  assign act = {busy, done, R_en, R_addr, W_en, W_addr,
                Yen_even, Yen_odd, Uen_even, Uen_odd, Ven_even, Ven_odd,
                Smux1, Smux2, Temp_en, Cen, end_of_pixel};

  // Memory and datapath model: one-cycle read latency, byte registers, temp.
  logic [15:0] rd_data = 16'h0000;
  logic [7:0] y_e = 8'h00, y_o = 8'h00, u_e = 8'h00, u_o = 8'h00, v_e = 8'h00, v_o = 8'h00;
  logic [7:0] temp_q = 8'h00;
  logic [7:0] comp;
  logic [15:0] w_data;

  always @(posedge clk) begin
    if (R_en) rd_data <= 16'h8080;
    if (Yen_even) y_e <= rd_data[7:0];
    if (Yen_odd)  y_o <= rd_data[15:8];
    if (Uen_even) u_e <= rd_data[7:0];
    if (Uen_odd)  u_o <= rd_data[15:8];
    if (Ven_even) v_e <= rd_data[7:0];
    if (Ven_odd)  v_o <= rd_data[15:8];
    if (Temp_en)  temp_q <= comp;
  end

  function automatic logic [7:0] dp_comp(logic s1, logic [1:0] s2,
                                         logic [7:0] ye, logic [7:0] yo,
                                         logic [7:0] ue, logic [7:0] uo,
                                         logic [7:0] ve, logic [7:0] vo);
    int y, u, v, r;
    y = s1 ? int'(ye) : int'(yo);
    u = (s1 ? int'(ue) : int'(uo)) - 128;
    v = (s1 ? int'(ve) : int'(vo)) - 128;
    case (s2)
      2'd0:    r = y + v;
      2'd1:    r = y - (u + v) / 2;
      2'd2:    r = y + u;
      default: r = 0;
    endcase
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  assign comp   = dp_comp(Smux1, Smux2, y_e, y_o, u_e, u_o, v_e, v_o);
  assign w_data = {temp_q, comp};

  always @(negedge clk) begin
    if (!rst && W_en) begin
      checks++;
      if (w_data !== 16'h8080) begin
        errors++;
        $display("FAIL wdata addr=%0d act=%h exp=8080", W_addr, w_data);
      end
    end
  end

  // Expected outputs for cycle c of a frame whose start was sampled at edge 0.
  function automatic vec_t model(int c);
    vec_t v;
    int p, ph;
    v = '0;
    v.smux2 = 2'd3;
    if (c >= 1 && c <= 10 * P) begin
      p  = (c - 1) / 10;
      ph = (c - 1) % 10;
      v.busy = 1'b1;
      case (ph)
        0: begin v.r_en = 1'b1; v.r_addr = AW'(YB + p); end
        1: begin v.r_en = 1'b1; v.r_addr = AW'(UB + p); v.en = 6'b110000; end
        2: begin v.r_en = 1'b1; v.r_addr = AW'(VB + p); v.en = 6'b001100; end
        3: v.en = 6'b000011;
        4: begin v.smux1 = 1'b1; v.smux2 = 2'd0; v.temp_en = 1'b1; end
        5: begin v.smux1 = 1'b1; v.smux2 = 2'd1; v.w_en = 1'b1; v.w_addr = AW'(WB + 3 * p); end
        6: begin v.smux1 = 1'b1; v.smux2 = 2'd2; v.temp_en = 1'b1; end
        7: begin v.smux2 = 2'd0; v.w_en = 1'b1; v.w_addr = AW'(WB + 3 * p + 1); end
        8: begin v.smux2 = 2'd1; v.temp_en = 1'b1; end
        default: begin
          v.smux2 = 2'd2; v.w_en = 1'b1; v.w_addr = AW'(WB + 3 * p + 2);
          v.cen = 1'b1; v.eop = (p == P - 1);
        end
      endcase
    end else if (c == 10 * P + 1) begin
      v.done = 1'b1;
    end
    return v;
  endfunction

  task automatic chk_vec(string name, int c, vec_t a, vec_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, c, a, e);
    end
  endtask

  task automatic chk_int(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, a, e);
    end
  endtask

  rec_t tbl[10 * P + 3];
  int done_cnt, done_cyc;

  initial begin
    for (int c = 0; c < 10 * P + 3; c++) tbl[c] = '{c, (c == 0), model(c)};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_vec("reset_idle", i, act, model(0));
    end

    // Two-pair frame, cycle by cycle.
    for (int i = 0; i < 10 * P + 3; i++) begin
      start = tbl[i].start;
      chk_vec("frame", tbl[i].cyc, act, tbl[i].exp);
      @(negedge clk);
    end
    start = 1'b0;

    // start pulses during a frame must not stretch it or add a done.
    start = 1'b1;
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      start = ((c % 3) == 0 && c < 20) ? 1'b1 : 1'b0;
    end
    chk_int("restart_done_cycle", done_cyc, 10 * P + 1);
    chk_int("restart_done_count", done_cnt, 1);

    // Reset in C3 abandons the frame; next start begins again at k=0.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk_vec("pre_rst_c3", 8, act, model(8));
    rst = 1'b1;
    @(negedge clk);
    chk_vec("rst_idle", 9, act, model(0));
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk_vec("rst_restart", 1, act, model(1));
    start = 1'b0;
    done_cyc = -1;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = c;
    end
    chk_int("rst_restart_done", done_cyc, 10 * P + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
